hard_reset_receiver: RTL
========================

Name: hard_reset_receiver

Overview:
Receive-side counterpart of the TCPC hard reset transmit path; handles Hard Reset and Cable Reset signaling detected by the PHY from the port partner.
- On an enabled detection: aborts the transmitter, requests a clear of RECEIVE_DETECT, raises ALERT.ReceivedHardReset (bit 3) to the TCPM, and waits for the TCPM acknowledge or a timeout.
- Then enforces a hold-off window before re-arming.
- Sits between the PHY receive front end and the TCPC register block.

Parameters:
ACK_TIMEOUT, 900, cycles in WAIT_ACK before giving up on the TCPM clearing ALERT[3]; must be >= 1
HOLDOFF_CYCLES, 16, cycles spent in HOLDOFF ignoring detections; must be >= 1
CNT_W, 10, cycle counter width; must hold max(ACK_TIMEOUT, HOLDOFF_CYCLES)

Ports:
CLK  input  1  single clock
reset  input  1  asynchronous, active-high reset
iRECEIVE_DETECT  input  8  RECEIVE_DETECT register; bit5 EnableHardReset, bit6 EnableCableReset, other bits unused
phy_hard_reset  input  1  one-cycle pulse: Hard Reset ordered set received
phy_cable_reset  input  1  one-cycle pulse: Cable Reset ordered set received
alert_clear  input  16  one-cycle write-1-to-clear strobe from a TCPM ALERT write
oALERT  output  16  ALERT bits owned by this block; only bit3 is ever set
oRECEIVE_DETECT_clr  output  1  one-cycle pulse; register block zeroes RECEIVE_DETECT
tx_abort  output  1  level; transmitter discards pending and ongoing messages
hr_type  output  1  type of last accepted reset: 0 hard, 1 cable
hr_busy  output  1  high whenever state != IDLE
hr_timeout  output  1  sticky; TCPM did not acknowledge within ACK_TIMEOUT
hr_drop_count  output  8  ignored-detection count (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state IDLE, counter 0.
  - All outputs 0: oALERT=16'h0000, hr_drop_count=0.
- States: IDLE, RESET_LAYER, INDICATE, WAIT_ACK, HOLDOFF. All outputs are registered.
- IDLE (detection sampled at edge k):
  - phy_hard_reset && iRECEIVE_DETECT[5]: go to RESET_LAYER with hr_type=0.
  - Else phy_cable_reset && iRECEIVE_DETECT[6]: go to RESET_LAYER with hr_type=1.
  - Hard and cable in the same cycle, both enabled: hard wins (hr_type=0).
  - Disabled detections are ignored.
- RESET_LAYER: exactly 1 cycle.
  - oRECEIVE_DETECT_clr=1 during this cycle only (cycle after edge k).
  - tx_abort rises in this cycle.
  - hr_timeout cleared, counter cleared.
  - Next state: INDICATE.
- INDICATE: 1 cycle.
  - oALERT[3] set; visible from the cycle after edge k+2 onward.
  - Next state: WAIT_ACK, counter 0.
- WAIT_ACK: counter increments each cycle.
  - alert_clear[3]=1: oALERT[3] cleared, counter 0, go to HOLDOFF.
  - Else if counter == ACK_TIMEOUT-1: hr_timeout=1, oALERT[3] stays set, counter 0, go to HOLDOFF.
  - Clear and timeout in the same cycle: the clear wins, hr_timeout stays 0.
- tx_abort: high during RESET_LAYER, INDICATE and WAIT_ACK; low in HOLDOFF and IDLE.
- HOLDOFF: counts HOLDOFF_CYCLES cycles, then goes to IDLE.
- Detections arriving in any state other than IDLE are ignored; no re-entry and no queuing.
- alert_clear outside WAIT_ACK:
  - Clears the corresponding oALERT bits in any state.
  - Set in INDICATE with a simultaneous alert_clear[3]: the set wins.
  - Bits other than 3 are always 0.
- Counter never wraps: it is reset on every state change and compared with ==.
- hr_type holds until the next accepted detection.

Optional Feature:
Macro HR_DROP_COUNT_EN.
- Defined: hr_drop_count is an 8-bit saturating counter (sticks at 255).
  - Increments once per cycle in which phy_hard_reset or phy_cable_reset is high and the detection is not accepted: state != IDLE, or the matching enable bit is 0.
  - Both pulses in one cycle count as 1.
  - Cleared only by reset.
- Undefined: the hr_drop_count port still exists and is tied to 8'h00; no counter logic is present.

Test Plan:
- iRECEIVE_DETECT=8'h20, phy_hard_reset pulse at edge 10 -> oRECEIVE_DETECT_clr high for one cycle after edge 10, tx_abort high, oALERT=16'h0008 from cycle after edge 12, hr_type=0, hr_busy=1.
- Continue; alert_clear=16'h0008 at edge 20 -> oALERT=0, tx_abort low, HOLDOFF for 16 cycles, hr_busy low after edge 36, hr_timeout=0.
- iRECEIVE_DETECT=8'h00, pulse phy_hard_reset and phy_cable_reset -> no state change; hr_drop_count=2 with HR_DROP_COUNT_EN, 0 without.
- iRECEIVE_DETECT=8'h60, both pulses in the same cycle -> hr_type=0. Then no alert_clear, ACK_TIMEOUT=900 -> hr_timeout=1 exactly 900 cycles after entering WAIT_ACK, oALERT[3] still 1, then HOLDOFF.
- phy_cable_reset with iRECEIVE_DETECT=8'h40, then phy_hard_reset during HOLDOFF -> cable reset accepted with hr_type=1; second pulse ignored (drop count +1).
- Assert reset asynchronously mid-WAIT_ACK (between edges) -> oALERT, tx_abort, hr_busy and hr_timeout drop to 0 immediately; state IDLE; the next enabled pulse is accepted normally.

Source files
------------

// File: rtl/hard_reset_receiver.sv
// Receive-side Hard Reset / Cable Reset handler for a TCPC.
// On an enabled detection it aborts the transmitter, asks the register block to zero
// RECEIVE_DETECT, raises ALERT[3], waits for the TCPM acknowledge (or times out) and
// then holds off further detections for HOLDOFF_CYCLES before re-arming.
// Optional: define HR_DROP_COUNT_EN to get a saturating count of ignored detections on
// hr_drop_count; otherwise the port is tied to zero.
module hard_reset_receiver #(
  parameter int unsigned ACK_TIMEOUT    = 900,
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter int unsigned CNT_W          = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  iRECEIVE_DETECT,
  input  logic        phy_hard_reset,
  input  logic        phy_cable_reset,
  input  logic [15:0] alert_clear,
  output logic [15:0] oALERT,
  output logic        oRECEIVE_DETECT_clr,
  output logic        tx_abort,
  output logic        hr_type,
  output logic        hr_busy,
  output logic        hr_timeout,
  output logic [7:0]  hr_drop_count
);

  typedef enum logic [2:0] {
    StIdle,
    StResetLayer,
    StIndicate,
    StWaitAck,
    StHoldoff
  } state_e;

  localparam logic [CNT_W-1:0] AckLast     = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HoldoffLast = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alert3_q, alert3_d;
  logic             rd_clr_q, rd_clr_d;
  logic             tx_abort_q, tx_abort_d;
  logic             hr_type_q, hr_type_d;
  logic             hr_busy_q, hr_busy_d;
  logic             hr_timeout_q, hr_timeout_d;

  logic accept_hard, accept_cable, accepted;

  assign accept_hard  = phy_hard_reset & iRECEIVE_DETECT[5];
  assign accept_cable = phy_cable_reset & iRECEIVE_DETECT[6];
  assign accepted     = (state_q == StIdle) & (accept_hard | accept_cable);

  // Only the enable bits and ALERT[3] matter to this block.
  logic unused_inputs;
  assign unused_inputs = ^{iRECEIVE_DETECT[7], iRECEIVE_DETECT[4:0],
                           alert_clear[15:4], alert_clear[2:0]};

  // Next-state and next-output computation for the sequence FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alert3_d     = alert3_q & ~alert_clear[3];
    rd_clr_d     = 1'b0;
    hr_type_d    = hr_type_q;
    hr_timeout_d = hr_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (accepted) begin
          state_d      = StResetLayer;
          hr_type_d    = ~accept_hard;  // hard wins when both are enabled and present
          rd_clr_d     = 1'b1;
          hr_timeout_d = 1'b0;
          cnt_d        = '0;
        end
      end
      StResetLayer: begin
        state_d = StIndicate;
        cnt_d   = '0;
      end
      StIndicate: begin
        alert3_d = 1'b1;  // set beats a simultaneous clear
        state_d  = StWaitAck;
        cnt_d    = '0;
      end
      StWaitAck: begin
        if (alert_clear[3]) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end else if (cnt_q == AckLast) begin
          hr_timeout_d = 1'b1;
          state_d      = StHoldoff;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHoldoff: begin
        if (cnt_q == HoldoffLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    tx_abort_d = (state_d == StResetLayer) | (state_d == StIndicate) | (state_d == StWaitAck);
    hr_busy_d  = (state_d != StIdle);
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alert3_q     <= 1'b0;
      rd_clr_q     <= 1'b0;
      tx_abort_q   <= 1'b0;
      hr_type_q    <= 1'b0;
      hr_busy_q    <= 1'b0;
      hr_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alert3_q     <= alert3_d;
      rd_clr_q     <= rd_clr_d;
      tx_abort_q   <= tx_abort_d;
      hr_type_q    <= hr_type_d;
      hr_busy_q    <= hr_busy_d;
      hr_timeout_q <= hr_timeout_d;
    end
  end

  assign oALERT              = {12'h000, alert3_q, 3'b000};
  assign oRECEIVE_DETECT_clr = rd_clr_q;
  assign tx_abort            = tx_abort_q;
  assign hr_type             = hr_type_q;
  assign hr_busy             = hr_busy_q;
  assign hr_timeout          = hr_timeout_q;

`ifdef HR_DROP_COUNT_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of cycles carrying a detection that was not accepted.
  always_comb begin
    drop_d = drop_q;
    if ((phy_hard_reset | phy_cable_reset) && !accepted && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Drop counter register; cleared only by reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      drop_q <= 8'h00;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign hr_drop_count = drop_q;
`else
  assign hr_drop_count = 8'h00;
`endif

endmodule
